// File: rtl/affine_interp_pkg.sv
// Shared constants and types for the affine interpolation filter: tap/phase counts
// and the multiplier-free coefficient table (each row sums to 1 << COEF_LOG2SUM).
package affine_interp_pkg;

    localparam int NTAPS        = 4;
    localparam int NPHASE       = 4;
    localparam int COEF_LOG2SUM = 3;
    localparam int COEF_W       = 4;

    typedef logic [1:0]        phase_t;
    typedef logic [COEF_W-1:0] coef_t;

    // Indexed [phase][tap], tap 0 is the oldest sample in the window
    localparam coef_t COEF_TABLE [NPHASE][NTAPS] = '{
        '{4'd0, 4'd8, 4'd0, 4'd0},
        '{4'd1, 4'd4, 4'd3, 4'd0},
        '{4'd0, 4'd4, 4'd4, 4'd0},
        '{4'd0, 4'd3, 4'd4, 4'd1}
    };

endpackage

// File: rtl/affine_mcm_tap.sv
// Combinational shift-add multiply of one signed sample by a coefficient from {0,1,3,4,8}.
module affine_mcm_tap
    import affine_interp_pkg::*;
#(
    parameter int SAMPLE_W = 8
) (
    input  logic signed [SAMPLE_W-1:0]              x,
    input  coef_t                                   coef,
    output logic signed [SAMPLE_W+COEF_LOG2SUM:0]   p
);

    localparam int PW = SAMPLE_W + COEF_LOG2SUM + 1;

    logic signed [PW-1:0] xe;

    assign xe = {{(PW-SAMPLE_W){x[SAMPLE_W-1]}}, x};

    always_comb begin
        p = '0;
        case (coef)
            4'd1:    p = xe;
            4'd3:    p = (xe <<< 2) - xe;
            4'd4:    p = xe <<< 2;
            4'd8:    p = xe <<< 3;
            default: p = '0;
        endcase
    end

endmodule

// File: rtl/affine_interp_filter_pipe.sv
// Two-stage 4-tap affine interpolation filter with a sliding sample window,
// per-sample phase select, round/saturate and valid/ready flow control.
module affine_interp_filter_pipe
    import affine_interp_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [SAMPLE_W-1:0]  in_data,
    input  logic                        in_sol,
    input  phase_t                      in_phase,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_W-1:0]     out_data
);

    localparam int PW = SAMPLE_W + COEF_LOG2SUM + 1;
    localparam int SW = PW + 1;
    localparam int RW = SW + 1;
    localparam int XW = RW + OUT_W;

    localparam logic signed [RW-1:0] RND_V   = RW'((1 << SHIFT) >> 1);
    localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic signed [RW-1:0] round_shift(input logic signed [SW-1:0] s);
        logic signed [RW-1:0] t;
        t = {s[SW-1], s};
        t = t + RND_V;
        return t >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [RW-1:0] v);
        logic signed [XW-1:0] w;
        w = {{OUT_W{v[RW-1]}}, v};
        if (w > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (w < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        return w[OUT_W-1:0];
    endfunction

    logic signed [SAMPLE_W-1:0] win     [NTAPS];
    logic signed [SAMPLE_W-1:0] tap_in  [NTAPS];
    logic signed [PW-1:0]       prod    [NTAPS];
    logic signed [PW-1:0]       prod_p1 [NTAPS];
    logic signed [SW-1:0]       sum_p1;
    logic [2:0]                 count;
    logic                       vld_p1;
    logic                       stall;
    logic                       accept;
    logic                       completes;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign completes = accept & ~in_sol & (count >= 3'd3);

    // Window as it looks once the incoming sample has been shifted in
    always_comb begin
        for (int i = 0; i < NTAPS-1; i++)
            tap_in[i] = win[i+1];
        tap_in[NTAPS-1] = in_data;
    end

    for (genvar t = 0; t < NTAPS; t++) begin : g_tap
        affine_mcm_tap #(.SAMPLE_W(SAMPLE_W)) u_tap (
            .x    (tap_in[t]),
            .coef (COEF_TABLE[in_phase][t]),
            .p    (prod[t])
        );
    end

    // Stale entries left behind by a start-of-line are shifted out before count reaches 4
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (accept)
            count <= in_sol ? 3'd1 : ((count == 3'd4) ? 3'd4 : count + 3'd1);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NTAPS; i++)
                win[i] <= tap_in[i];
        end
    end

    // Stage 1: tap products
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (!stall)
            vld_p1 <= completes;
    end

    always_ff @(posedge clk) begin
        if (!stall && completes) begin
            for (int i = 0; i < NTAPS; i++)
                prod_p1[i] <= prod[i];
        end
    end

    always_comb begin
        sum_p1 = '0;
        for (int i = 0; i < NTAPS; i++)
            sum_p1 = sum_p1 + {prod_p1[i][PW-1], prod_p1[i]};
    end

    // Stage 2: sum, round, saturate
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            out_valid <= vld_p1;
            if (vld_p1)
                out_data <= saturate(round_shift(sum_p1));
        end
    end

endmodule

// File: tb/tb_affine_interp_filter_pipe.sv
// Scoreboard bench: two instances (SHIFT=3/OUT_W=16 and SHIFT=0/OUT_W=10) share one stream;
// hand-computed expected pairs are queued on accept and popped by an output monitor.
`timescale 1ns/1ps
module tb_affine_interp_filter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                in_valid;
    logic                in_sol;
    logic signed [7:0]   in_data;
    logic [1:0]          in_phase;
    logic                out_ready;
    logic                in_ready_a, in_ready_b;
    logic                out_valid_a, out_valid_b;
    logic signed [15:0]  out_data_a;
    logic signed [9:0]   out_data_b;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    typedef struct { int a; int b; } exp_t;
    exp_t q[$];

    affine_interp_filter_pipe #(.SAMPLE_W(8), .OUT_W(16), .SHIFT(3)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_sol(in_sol), .in_phase(in_phase),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
    );

    affine_interp_filter_pipe #(.SAMPLE_W(8), .OUT_W(10), .SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_sol(in_sol), .in_phase(in_phase),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
    );

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic sol, input logic [1:0] ph, input int d,
                        input logic has, input int ea, input int eb);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sol   = sol;
        in_phase = ph;
        in_data  = 8'(d);
        #1;
        while (!(in_ready_a && in_ready_b) && guard < 64) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!(in_ready_a && in_ready_b)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready %0d/%0d required 1", in_ready_a, in_ready_b);
        end else if (has) begin
            q.push_back(exp_t'{ea, eb});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Start-of-line on d0; phase only matters on the completing sample d3
    task automatic line4(input int d0, input int d1, input int d2, input int d3,
                         input logic [1:0] ph, input int ea, input int eb);
        send(1'b1, 2'd3, d0, 1'b0, 0, 0);
        send(1'b0, 2'd3, d1, 1'b0, 0, 0);
        send(1'b0, 2'd3, d2, 1'b0, 0, 0);
        send(1'b0, ph,   d3, 1'b1, ea, eb);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic stall_window(input int n);
        int guard = 0;
        logic signed [31:0] held_a, held_b;
        @(negedge clk);
        while (!out_valid_a && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        chk("stall_start_vld", out_valid_a, 1);
        out_ready = 1'b0;
        #2;
        held_a = out_data_a;
        held_b = out_data_b;
        for (int i = 0; i < n; i++) begin
            chk("stall_in_ready_a", in_ready_a, 0);
            chk("stall_in_ready_b", in_ready_b, 0);
            chk("stall_vld", out_valid_a, 1);
            chk("stall_hold_a", out_data_a, held_a);
            chk("stall_hold_b", out_data_b, held_b);
            @(negedge clk);
            if (i < n - 1) #2;
        end
        out_ready = 1'b1;
    endtask

    // Output monitor: pop one expected pair per completed handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_ready && out_valid_a) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0d/%0d required no output", out_data_a, out_data_b);
                end else begin
                    e = q.pop_front();
                    chk("out_a", out_data_a, e.a);
                    chk("out_b", out_data_b, e.b);
                    chk("out_vld_b", out_valid_b, 1);
                end
                n_out++;
            end else if (!rst && out_ready && out_valid_b) begin
                checks++;
                errors++;
                $display("FAIL vld_b_alone: got out_valid_b 1 required 0");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sol    = 1'b0;
        in_data   = '0;
        in_phase  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_vld_a", out_valid_a, 0);
        chk("rst_vld_b", out_valid_b, 0);
        chk("rst_data_a", out_data_a, 0);
        chk("rst_data_b", out_data_b, 0);
        chk("rst_rdy_a", in_ready_a, 1);
        chk("rst_rdy_b", in_ready_b, 1);

        // Warm-up: P2 on {10,20,30,40} = 200 -> 25 after rounding shift
        line4(10, 20, 30, 40, 2'd2, 25, 200);
        chk("lat_c1", out_valid_a, 0);
        @(posedge clk);
        #1;
        chk("lat_c2", out_valid_a, 1);
        idle(6);
        chk("warmup_count", n_out, 1);

        // Phase sweep over the same window
        line4(10, 20, 30, 40, 2'd0, 20, 160);
        line4(10, 20, 30, 40, 2'd1, 23, 180);
        line4(10, 20, 30, 40, 2'd3, 28, 220);

        // Extremes: raw sums of +-1016/-1024 saturate in the 10-bit raw instance
        line4(-128, -128, -128, -128, 2'd0, -128, -512);
        line4(127, 127, 127, 127, 2'd2, 127, 511);
        line4(127, 127, 127, 127, 2'd0, 127, 511);
        // -40 + 4 = -36, floor(-36 / 8) = -5
        line4(-3, -5, -7, -9, 2'd0, -5, -40);
        idle(6);
        chk("pre_stream_drain", q.size(), 0);

        // Continuous stream with a 5-cycle backpressure window and a mid-stream start-of-line
        fork
            begin
                send(1'b1, 2'd0, 1, 1'b0, 0, 0);
                send(1'b0, 2'd0, 2, 1'b0, 0, 0);
                send(1'b0, 2'd0, 3, 1'b0, 0, 0);
                send(1'b0, 2'd0, 4, 1'b1, 2, 16);
                send(1'b0, 2'd1, 5, 1'b1, 3, 26);
                send(1'b0, 2'd2, 6, 1'b1, 5, 36);
                send(1'b0, 2'd3, 7, 1'b1, 6, 46);
                send(1'b0, 2'd1, 8, 1'b1, 6, 50);
                send(1'b1, 2'd0, 100, 1'b0, 0, 0);
                send(1'b0, 2'd0, 101, 1'b0, 0, 0);
                send(1'b0, 2'd0, 102, 1'b0, 0, 0);
                send(1'b0, 2'd2, 103, 1'b1, 102, 511);
            end
            stall_window(5);
        join
        idle(8);
        chk("stream_drain", q.size(), 0);
        chk("stream_count", n_out, 14);

        // Reset while stalled drops the held result and empties the window
        @(negedge clk);
        out_ready = 1'b0;
        line4(50, 60, 70, 80, 2'd0, 60, 480);
        begin
            int guard = 0;
            @(negedge clk);
            while (!out_valid_a && guard < 64) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("rst_stall_vld", out_valid_a, 1);
        chk("rst_stall_rdy", in_ready_a, 0);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        #1;
        chk("rst_mid_vld_a", out_valid_a, 0);
        chk("rst_mid_vld_b", out_valid_b, 0);
        chk("rst_mid_data_a", out_data_a, 0);
        chk("rst_mid_rdy", in_ready_a, 1);
        rst       = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        send(1'b0, 2'd2, 8, 1'b0, 0, 0);
        send(1'b0, 2'd2, 8, 1'b0, 0, 0);
        send(1'b0, 2'd2, 8, 1'b0, 0, 0);
        idle(6);
        chk("post_rst_three", n_out, n0);
        send(1'b0, 2'd2, 8, 1'b1, 8, 64);
        idle(6);
        chk("post_rst_four", n_out, n0 + 1);
        chk("final_drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
